// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation engine.
//   BLK_SIZE      : block edge length in pixels
//   PIX_W         : pixel width in bits
//   WORDS_PER_BLK : 32-bit words that make up one 8x8 block
//   fetch_state_t : current-block fetch sequencer states
package me_pkg;

   localparam int BLK_SIZE      = 8;
   localparam int PIX_W         = 8;
   localparam int WORDS_PER_BLK = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/cur_addr_gen.sv
// Frame-memory word-address generator for one 8x8 block.
// Latches the block base address on load, then walks the 16 words
// {row, half} in order, moving to the next word on each grant.
//   clk, rst      : clock, async active-low reset
//   load          : capture base address from blk_x/blk_y, restart at word 0
//   blk_x, blk_y  : block column/row index
//   adv           : current word was granted, move to the next one
//   addr          : word address of the current word
module cur_addr_gen #(
   parameter int FRAME_W = 64,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [7:0]        blk_x,
   input  logic [7:0]        blk_y,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr
);

   localparam int ROW_WORDS = FRAME_W / 4;

   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] base_calc;
   logic [3:0]        widx;

   // (y*8*W + x*8)/4 reduces exactly to y*2*W + x*2; computing in ADDR_W
   // bits gives the same modulo-2^ADDR_W result as the full expression.
   assign base_calc = ADDR_W'(blk_y) * ADDR_W'(2 * FRAME_W)
                    + ADDR_W'({blk_x, 1'b0});

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q <= '0;
         widx   <= '0;
      end else if (load) begin
         base_q <= base_calc;
         widx   <= '0;
      end else if (adv) begin
         widx   <= widx + 4'd1;
      end
   end

   assign addr = base_q + ADDR_W'(widx[3:1]) * ADDR_W'(ROW_WORDS)
               + ADDR_W'(widx[0]);

endmodule

// File: rtl/cur_blk_fetch_ctrl.sv
// Current-block fetch sequencer: loads one 8x8 block from frame memory
// into the cur_reg array and hands it to the SAD engine.
//   start/start_rdy/blk_x/blk_y/err : fetch command, err on bad indices
//   mem_req/mem_addr/mem_gnt        : read request channel
//   mem_rvalid/mem_rdata            : in-order read return
//   cur_we/cur_widx/cur_wdata       : cur_reg write port
//   blk_valid/blk_ack               : block handoff to SAD engine
//   busy                            : FETCH or HOLD
//
// state | meaning
// IDLE  | ready for start
// FETCH | issuing reads / writing returned words into cur_reg
// HOLD  | block complete, blk_valid until blk_ack
module cur_blk_fetch_ctrl
   import me_pkg::*;
#(
   parameter int FRAME_W   = 64,
   parameter int FRAME_H   = 64,
   parameter int ADDR_W    = 16,
   parameter int MAX_OUTST = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              start_rdy,
   input  logic [7:0]        blk_x,
   input  logic [7:0]        blk_y,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              cur_we,
   output logic [3:0]        cur_widx,
   output logic [31:0]       cur_wdata,
   output logic              blk_valid,
   input  logic              blk_ack,
   output logic              busy
);

   localparam logic [4:0] N_WORDS = 5'(WORDS_PER_BLK);

   fetch_state_t state, state_nxt;
   logic [4:0]   issue_cnt;
   logic [4:0]   recv_cnt;
   logic [4:0]   outst;
   logic         start_acc;
   logic         blk_ok;
   logic         load;
   logic         grant;
   logic         rv_take;

   assign blk_ok    = (int'(blk_x) < FRAME_W / BLK_SIZE)
                   && (int'(blk_y) < FRAME_H / BLK_SIZE);
   assign start_acc = start && (state == IDLE);
   assign load      = start_acc && blk_ok;

   // Slot accounting uses registered counts only, so a return in the
   // current cycle frees its slot one cycle later.
   assign outst   = issue_cnt - recv_cnt;
   assign mem_req = (state == FETCH) && (issue_cnt < N_WORDS)
                 && (outst < 5'(MAX_OUTST));
   assign grant   = mem_req && mem_gnt;
   assign rv_take = (state == FETCH) && mem_rvalid && (recv_cnt < N_WORDS);

   assign start_rdy = (state == IDLE);
   assign busy      = (state != IDLE);
   assign blk_valid = (state == HOLD);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load) state_nxt = FETCH;
         FETCH:   if (recv_cnt == N_WORDS) state_nxt = HOLD;
         HOLD:    if (blk_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         err       <= 1'b0;
         issue_cnt <= '0;
         recv_cnt  <= '0;
         cur_we    <= 1'b0;
         cur_widx  <= '0;
         cur_wdata <= '0;
      end else begin
         state  <= state_nxt;
         err    <= start_acc && !blk_ok;
         cur_we <= rv_take;
         if (load) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
         end else begin
            if (grant)   issue_cnt <= issue_cnt + 5'd1;
            if (rv_take) recv_cnt  <= recv_cnt + 5'd1;
         end
         if (rv_take) begin
            cur_widx  <= recv_cnt[3:0];
            cur_wdata <= mem_rdata;
         end
      end
   end

   cur_addr_gen #(
      .FRAME_W (FRAME_W),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .blk_x (blk_x),
      .blk_y (blk_y),
      .adv   (grant),
      .addr  (mem_addr)
   );

endmodule

// File: tb/tb_cur_blk_fetch_ctrl.sv
module tb_cur_blk_fetch_ctrl;

   localparam int FRAME_W   = 64;
   localparam int FRAME_H   = 64;
   localparam int ADDR_W    = 16;
   localparam int MAX_OUTST = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              start_rdy;
   logic [7:0]        blk_x = '0;
   logic [7:0]        blk_y = '0;
   logic              err;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt = 1'b0;
   logic              mem_rvalid = 1'b0;
   logic [31:0]       mem_rdata = '0;
   logic              cur_we;
   logic [3:0]        cur_widx;
   logic [31:0]       cur_wdata;
   logic              blk_valid;
   logic              blk_ack = 1'b0;
   logic              busy;

   cur_blk_fetch_ctrl #(
      .FRAME_W   (FRAME_W),
      .FRAME_H   (FRAME_H),
      .ADDR_W    (ADDR_W),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_rdy  (start_rdy),
      .blk_x      (blk_x),
      .blk_y      (blk_y),
      .err        (err),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_gnt    (mem_gnt),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .cur_we     (cur_we),
      .cur_widx   (cur_widx),
      .cur_wdata  (cur_wdata),
      .blk_valid  (blk_valid),
      .blk_ack    (blk_ack),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int t0 = 0;
   int lat = 1;
   int gnt_mode = 0;
   int base = 0;
   int g_cnt = 0;
   int rv_cnt = 0;
   int mon_idx = 0;
   int out_max = 0;
   int throttled = 0;
   int n = 0;
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr = '0;
   logic              ring_v [16];
   logic [31:0]       ring_d [16];
   logic [7:0]        pix [64];

   function automatic logic [31:0] word_data(input int k);
      return 32'h0302_0100 + 32'(k) * 32'h0404_0404;
   endfunction

   function automatic logic [31:0] exp_addr(input int k);
      return 32'(base + (k / 2) * (FRAME_W / 4) + (k % 2));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample DUT at the falling edge, check the write port,
   // model the memory (grant policy, fixed-latency in-order returns).
   task automatic tick();
      int slot;
      @(negedge clk);
      cyc++;
      if (cur_we) begin
         check("widx", 32'(cur_widx), 32'(mon_idx));
         check("wdata", cur_wdata, word_data(mon_idx));
         for (int b = 0; b < 4; b++)
            pix[int'(cur_widx) * 4 + b] = cur_wdata[8*b +: 8];
         mon_idx++;
      end
      if (prev_stall) check("addr_hold", 32'(mem_addr), 32'(prev_addr));
      if (mem_req) check("outst_lim", 32'((g_cnt - rv_cnt) < MAX_OUTST), 32'd1);
      if (g_cnt - rv_cnt > out_max) out_max = g_cnt - rv_cnt;
      if (busy && !blk_valid && !mem_req && g_cnt < 16) throttled++;
      case (gnt_mode)
         0:       mem_gnt = 1'b1;
         1:       mem_gnt = 1'($urandom_range(0, 1));
         default: mem_gnt = 1'b0;
      endcase
      if (mem_req && mem_gnt) begin
         check("addr", 32'(mem_addr), exp_addr(g_cnt));
         slot = (cyc + lat) % 16;
         ring_v[slot] = 1'b1;
         ring_d[slot] = word_data(g_cnt);
         g_cnt++;
      end
      prev_stall = mem_req && !mem_gnt;
      prev_addr  = mem_addr;
      slot = cyc % 16;
      mem_rvalid = ring_v[slot];
      mem_rdata  = ring_v[slot] ? ring_d[slot] : 32'd0;
      ring_v[slot] = 1'b0;
      if (mem_rvalid) rv_cnt++;
   endtask

   task automatic start_blk(input int bx, input int by);
      blk_x = 8'(bx);
      blk_y = 8'(by);
      start = 1'b1;
      base = (by * 8 * FRAME_W + bx * 8) / 4;
      g_cnt = 0;
      rv_cnt = 0;
      mon_idx = 0;
      out_max = 0;
      throttled = 0;
      for (int i = 0; i < 64; i++) pix[i] = 8'd0;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      n = 0;
      while (!blk_valid && n < 400) begin
         tick();
         n++;
      end
      check(tag, 32'(blk_valid), 32'd1);
   endtask

   task automatic check_pixels(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (pix[i] !== 8'(i)) bad++;
      check(tag, 32'(bad), 32'd0);
   endtask

   task automatic ack_blk();
      blk_ack = 1'b1;
      tick();
      blk_ack = 1'b0;
      check("ack_idle", 32'({start_rdy, busy, blk_valid}), 32'b100);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ring_v[i] = 1'b0;
         ring_d[i] = '0;
      end

      // reset values
      tick();
      tick();
      check("rst_rdy", 32'(start_rdy), 32'd1);
      check("rst_ctl", 32'({err, mem_req, cur_we, blk_valid, busy}), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_widx", 32'(cur_widx), 32'd0);
      check("rst_wdata", cur_wdata, 32'd0);
      rst = 1'b1;
      tick();

      // best case: gnt=1, L=1, block (1,2) -> base 258, blk_valid at cycle 19
      lat = 1;
      gnt_mode = 0;
      start_blk(1, 2);
      check("a_busy", 32'({busy, start_rdy}), 32'b10);
      check("a_first_addr", 32'(mem_addr), 32'd258);
      wait_valid("a_done");
      check("a_valid_cyc", 32'(cyc - t0), 32'd19);
      check("a_words", 32'(mon_idx), 32'd16);
      check("a_reqs", 32'(g_cnt), 32'd16);
      check_pixels("a_pixels");

      // start during HOLD, then start together with blk_ack: both ignored
      start = 1'b1;
      tick();
      check("hold_start_ign", 32'({blk_valid, start_rdy}), 32'b10);
      blk_ack = 1'b1;
      tick();
      start = 1'b0;
      blk_ack = 1'b0;
      check("hold_ack_rdy", 32'({start_rdy, busy, mem_req}), 32'b100);
      tick();
      check("hold_no_refetch", 32'({start_rdy, busy, mem_req}), 32'b100);

      // out-of-range indices
      start_blk(8, 0);
      check("errx_pulse", 32'(err), 32'd1);
      check("errx_idle", 32'({start_rdy, busy, mem_req}), 32'b100);
      tick();
      check("errx_clear", 32'({err, mem_req}), 32'd0);
      start_blk(0, 8);
      check("erry_pulse", 32'(err), 32'd1);
      check("erry_idle", 32'({start_rdy, busy, mem_req}), 32'b100);
      tick();
      check("erry_clear", 32'(err), 32'd0);

      // MAX_OUTST=2 with L=5, corner block (7,7) -> base 910
      lat = 5;
      start_blk(7, 7);
      check("c_first_addr", 32'(mem_addr), 32'd910);
      wait_valid("c_done");
      check("c_words", 32'(mon_idx), 32'd16);
      check("c_out_max", 32'(out_max), 32'd2);
      check("c_throttled", 32'(throttled > 0), 32'd1);
      check_pixels("c_pixels");
      ack_blk();

      // random 50% grant, L=2, block (3,0) -> base 6
      lat = 2;
      gnt_mode = 1;
      start_blk(3, 0);
      wait_valid("d_done");
      check("d_words", 32'(mon_idx), 32'd16);
      check("d_reqs", 32'(g_cnt), 32'd16);
      check_pixels("d_pixels");
      ack_blk();

      // reset with recv_cnt=7 and two reads in flight, then refetch
      lat = 5;
      gnt_mode = 0;
      start_blk(0, 1);
      n = 0;
      while (mon_idx < 7 && n < 200) begin
         tick();
         n++;
      end
      check("e_reach7", 32'(mon_idx), 32'd7);
      check("e_inflight", 32'(g_cnt - mon_idx), 32'd2);
      rst = 1'b0;
      #1;
      check("e_rst_out", 32'({start_rdy, mem_req, cur_we, blk_valid, busy, err}), 32'b100000);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("e_no_late_we", 32'(mon_idx), 32'd7);
      check("e_idle", 32'({start_rdy, busy}), 32'b10);
      start_blk(0, 1);
      check("e_first_addr", 32'(mem_addr), 32'd128);
      wait_valid("e_done");
      check("e_words", 32'(mon_idx), 32'd16);
      check("e_reqs", 32'(g_cnt), 32'd16);
      check_pixels("e_pixels");
      ack_blk();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cur_blk_fetch_ctrl.md
# cur_blk_fetch_ctrl

Sequencer that fills the 8x8 current-block pixel register array (`cur_reg`) of the motion-estimation engine from frame memory. On a start command it computes the frame addresses of one 8x8 block, issues 16 32-bit word reads with a bounded number outstanding, and streams returned words into the register array with a write index. It then holds a block-valid flag until the SAD engine acknowledges. It sits between the frame-memory read port and `cur_reg`/SAD control.

## Interface
Parameters:
- FRAME_W, 64, frame width in pixels; multiple of 8
- FRAME_H, 64, frame height in pixels; multiple of 8
- ADDR_W, 16, memory word-address width
- MAX_OUTST, 4, maximum outstanding reads, 1..8

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-low
- start  in  1  block-fetch request; accepted only when start_rdy=1
- start_rdy  out  1  high in IDLE
- blk_x  in  8  block column index, sampled when start is accepted
- blk_y  in  8  block row index, sampled when start is accepted
- err  out  1  one-cycle pulse: accepted start had out-of-range indices
- mem_req  out  1  read request; held until mem_gnt
- mem_addr  out  ADDR_W  word address; stable while mem_req=1 and mem_gnt=0
- mem_gnt  in  1  request accepted when mem_req & mem_gnt
- mem_rvalid  in  1  read data valid; in request order, any latency ≥1
- mem_rdata  in  32  4 pixels, byte 0 = leftmost pixel
- cur_we  out  1  write strobe to cur_reg
- cur_widx  out  4  word index {row[2:0], half}; half 0 = pixels 0-3, half 1 = pixels 4-7
- cur_wdata  out  32  mem_rdata, registered
- blk_valid  out  1  all 16 words written; held until blk_ack
- blk_ack  in  1  SAD engine consumed the block
- busy  out  1  high in FETCH or HOLD

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: start_rdy=1. On start: if blk_x ≥ FRAME_W/8 or blk_y ≥ FRAME_H/8, pulse err next cycle, stay IDLE. Otherwise latch the base address and go to FETCH.
- Base word address: (blk_y·8·FRAME_W + blk_x·8)/4. Word k = {r,h} has address base + r·(FRAME_W/4) + h. All arithmetic is unsigned, truncated to ADDR_W.
- FETCH:
  - issue_cnt (0..16) advances on each grant.
  - recv_cnt (0..16) advances on each mem_rvalid.
  - outst = issue_cnt − recv_cnt.
  - mem_req=1 while issue_cnt<16 and outst<MAX_OUTST, both from registered values. An rvalid in the same cycle does not free a slot until the next cycle.
  - Each mem_rvalid gives cur_we=1, cur_widx=recv_cnt and cur_wdata=mem_rdata on the next cycle.
  - When recv_cnt reaches 16, go to HOLD.
- HOLD: blk_valid=1. On blk_ack, go to IDLE next cycle. blk_ack outside HOLD is ignored.
- start while busy is ignored (not queued).
- mem_rvalid in IDLE or HOLD is ignored: no cur_we.
- Reset mid-operation returns to IDLE and clears the counters. Data still in flight after reset release is discarded by the rule above.

## Timing
- Reset values: start_rdy=1; every other output 0.
- start accepted at cycle 0: FETCH at cycle 1, first mem_req with word-0 address at cycle 1.
- One request per cycle under continuous grant.
- cur_we lags mem_rvalid by exactly 1 cycle.
- blk_valid rises the cycle after the 16th cur_we. start_rdy returns the cycle after blk_ack.
- Best case (gnt always 1, read latency L, MAX_OUTST ≥ L+1):
  - last request at cycle 16
  - last cur_we at cycle 17+L
  - blk_valid at cycle 18+L
- err is asserted at cycle 1 for an invalid start.

## Structure
- Shared package `me_pkg` holds:
  - BLK_SIZE=8, PIX_W=8, WORDS_PER_BLK=16
  - the fetch-state enum (IDLE/FETCH/HOLD)
- Sub-module `cur_addr_gen` is natural: base-address latch plus {r,h} → address computation, advanced by grant.
- FSM, counters and the write path stay in the top.

## Test plan
- FRAME_W=64, blk_x=1, blk_y=2, gnt=1, L=1 → mem_addr sequence 258,259,274,275,…,370,371. cur_widx 0..15 in order. blk_valid at cycle 19.
- Memory returns 0x03020100+k·0x04040404 for word k → cur_wdata matches per cur_widx. cur_reg rows hold pixel values 0..63 in raster order.
- MAX_OUTST=2, L=5 → outst never exceeds 2. mem_req drops while 2 are outstanding. All 16 words arrive in order.
- mem_gnt random 50% → mem_addr stable across stalls. No address skipped or repeated.
- Out-of-range and mid-operation reset cases:
  - blk_x=8 with FRAME_W=64 → err pulse at cycle 1, no mem_req, start_rdy stays 1.
  - rst low at recv_cnt=7, with 2 reads in flight → outputs reset. Late rvalids produce no cur_we. A new start fetches all 16 words.
- start during HOLD, then blk_ack with start high in the same cycle → the start is ignored. start_rdy=1 the next cycle, and a start then accepted fetches normally.
